des_region_scheduler: RTL and testbench
=======================================

// Module: des_region_scheduler
// PURPOSE
//   Dispatches a contiguous range of DES key-search regions to NUM_CORES des_block_wrapper
//   instances and collects their results. For each core it sequences
//   READ_REGION -> START -> wait done -> report result -> RESTART.
//   Completed (region, counter) pairs go to the CPU through one valid/ready result port.
// PARAMETERS
//   NUM_CORES  4   number of des_block_wrapper instances driven (1..16)
//   REGION_W   16  region index width; matches the wrapper's region[15:0]
//   CNT_W      64  width of the wrapper's counter output
// PORTS
//   clk            in   1            clock
//   rst            in   1            synchronous reset, active-high
//   job_start      in   1            pulse: latch region_first/region_last and start a job
//   region_first   in   REGION_W     first region of the job
//   region_last    in   REGION_W     last region of the job (inclusive)
//   busy           out  1            job in progress
//   all_done       out  1            job finished; held until the next accepted job_start
//   core_cmd       out  32*NUM_CORES per-core command: 0=READ_REGION, 1=START, 3=RESTART
//   core_cmd_valid out  NUM_CORES    per-core command valid
//   core_region    out  32*NUM_CORES per-core region; upper bits zero
//   core_cmd_read  in   NUM_CORES    per-core command accepted (pulse from the wrapper)
//   core_done      in   NUM_CORES    per-core search finished (level from the wrapper)
//   core_counter   in   CNT_W*NUM_CORES  per-core counter result
//   res_valid      out  1            result available
//   res_ready      in   1            CPU accepts the result
//   res_region     out  REGION_W     region of the result
//   res_counter    out  CNT_W        counter of the result
// BEHAVIOUR
// - Reset: busy, all_done, res_valid, and all core_cmd_valid = 0; core_cmd, core_region,
//   res_region, res_counter = 0; every core FSM in IDLE. The integrator ties the
//   wrappers' rst_n = ~rst. A reset mid-job drops the job and any pending result.
// - Job start: job_start while !busy latches next_reg = region_first and
//   last_reg = region_last, sets busy, clears all_done. job_start while busy is ignored.
// - next_reg is REGION_W+1 bits wide, so region_last = all-ones must not wrap.
//   The range is exhausted when next_reg > last_reg.
// - If region_last < region_first, the job dispatches nothing. all_done=1 and busy=0
//   one cycle after job_start.
// - Allocation:
//   - At most one region is dispatched per cycle, to the lowest-index core in IDLE,
//     while the range is not exhausted.
//   - That core latches the region and next_reg increments.
//   - The first core_cmd_valid rises 1 cycle after job_start.
// - Per-core FSM (all outputs registered):
//   IDLE     -> LOAD on dispatch
//   LOAD     cmd=0, valid=1, region driven; on core_cmd_read: valid=0 next cycle -> START
//   START    cmd=1, valid=1; on core_cmd_read -> RUN (valid=0)
//   RUN      wait for core_done=1 -> REPORT; capture core_counter on the same edge
//   REPORT   wait for the result-port grant
//   RESTART  cmd=3, valid=1; on core_cmd_read -> IDLE
// - Command valid always drops the cycle after core_cmd_read is sampled, so the wrapper
//   never decodes a command twice. core_cmd and core_region stay stable while valid=1.
// - Result port:
//   - Round-robin grant among REPORT cores; the pointer starts at core 0 and moves to
//     the granted core + 1.
//   - The grant loads res_region/res_counter and sets res_valid the next cycle.
//     The granted core then goes to RESTART.
//   - res_valid and the data hold until res_valid & res_ready. The next grant may load
//     in the cycle after that handshake.
//   - One result at most in flight; no result is dropped or duplicated.
// - A core returning to IDLE is eligible for dispatch in the same cycle it is sampled IDLE.
// - Job completion:
//   - all_done=1 and busy=0 once the range is exhausted, every core is IDLE, and no
//     result is pending.
//   - all_done stays set until the next accepted job_start.
// TESTING
// - NUM_CORES=4, job 0x0010..0x0013, each core_done 20 cycles after START:
//   -> exactly four results with regions {0x10..0x13}, each counter matching its core;
//   all_done=1 after the last res handshake.
// - job 5..2 (last < first) -> no core_cmd_valid ever; busy=0, all_done=1 one cycle
//   after job_start.
// - job 0xFFFE..0xFFFF -> regions 0xFFFE and 0xFFFF dispatched once each;
//   no wrap to 0x0000.
// - All 4 cores raise core_done the same cycle, res_ready held low 10 cycles ->
//   res_valid holds core 0's data; release gives cores 0,1,2,3 in order.
// - job_start pulsed mid-job -> ignored; region sequence unchanged.
// - rst asserted while cores are in RUN -> next cycle all valids 0, busy=0, res_valid=0;
//   a fresh job 0x0..0x1 then completes normally.

Source files
------------

// File: rtl/des_region_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : des_region_scheduler                                       |
// | Description : Hands a contiguous range of DES key-search regions out to  |
// |               NUM_CORES des_block_wrapper instances, sequencing each one |
// |               through READ_REGION -> START -> done -> RESTART, and       |
// |               returns (region, counter) results on one valid/ready port. |
// | Ports       : clk, rst (sync, active-high)                               |
// |               job_start, region_first, region_last -> job request        |
// |               busy, all_done                       -> job status         |
// |               core_cmd/_valid/_region, core_cmd_read,                    |
// |               core_done, core_counter              -> per-core link      |
// |               res_valid, res_ready, res_region, res_counter -> results   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module des_region_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int REGION_W  = 16,
    parameter int CNT_W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_start,
    input  logic [REGION_W-1:0]        region_first,
    input  logic [REGION_W-1:0]        region_last,
    output logic                       busy,
    output logic                       all_done,
    output logic [32*NUM_CORES-1:0]    core_cmd,
    output logic [NUM_CORES-1:0]       core_cmd_valid,
    output logic [32*NUM_CORES-1:0]    core_region,
    input  logic [NUM_CORES-1:0]       core_cmd_read,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [CNT_W*NUM_CORES-1:0] core_counter,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [REGION_W-1:0]        res_region,
    output logic [CNT_W-1:0]           res_counter
);

    localparam int c_PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_START   = 3'd2;
    localparam logic [2:0] c_ST_RUN     = 3'd3;
    localparam logic [2:0] c_ST_REPORT  = 3'd4;
    localparam logic [2:0] c_ST_RESTART = 3'd5;

    localparam logic [1:0] c_CMD_READ    = 2'd0;
    localparam logic [1:0] c_CMD_START   = 2'd1;
    localparam logic [1:0] c_CMD_RESTART = 2'd3;

    // Job state. The range pointers carry one extra bit so that a job ending
    // at the all-ones region terminates instead of wrapping to zero.
    logic                r_busy;
    logic                r_all_done;
    logic [REGION_W:0]   r_next_reg;
    logic [REGION_W:0]   r_last_reg;

    logic                r_res_valid;
    logic [REGION_W-1:0] r_res_region;
    logic [CNT_W-1:0]    r_res_counter;
    logic [c_PTR_W-1:0]  r_rr_ptr;

    logic [NUM_CORES-1:0] w_idle;
    logic [NUM_CORES-1:0] w_report;
    logic [NUM_CORES-1:0] w_disp;
    logic [NUM_CORES-1:0] w_sel;
    logic [NUM_CORES-1:0] w_grant;
    logic [REGION_W-1:0]  w_core_reg [NUM_CORES];
    logic [CNT_W-1:0]     w_core_cnt [NUM_CORES];

    logic                w_accept;
    logic                w_empty_job;
    logic [REGION_W:0]   w_cur;
    logic [REGION_W:0]   w_lim;
    logic                w_avail;
    logic                w_dispatch;
    logic                w_exhausted;
    logic                w_finished;
    logic                w_any_idle;
    logic                w_found;
    logic                w_do_grant;
    logic [c_PTR_W-1:0]  w_gidx;
    logic [c_PTR_W-1:0]  w_ptr_nxt;
    logic [REGION_W-1:0] w_g_region;
    logic [CNT_W-1:0]    w_g_counter;

    // On the accepting cycle the range comes straight from the inputs so the
    // first region is dispatched on the same edge that latches the job.
    assign w_accept    = job_start & ~r_busy;
    assign w_empty_job = (region_last < region_first);
    assign w_cur       = w_accept ? {1'b0, region_first} : r_next_reg;
    assign w_lim       = w_accept ? {1'b0, region_last}  : r_last_reg;
    assign w_avail     = (w_accept | r_busy) & (w_cur <= w_lim);
    assign w_exhausted = (r_next_reg > r_last_reg);
    assign w_finished  = r_busy & w_exhausted & (&w_idle) & ~r_res_valid;
    assign w_dispatch  = |w_disp;

    // Lowest-index idle core takes the next region.
    always_comb begin
        w_any_idle = 1'b0;
        w_disp     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_any_idle && w_idle[i]) begin
                w_any_idle = 1'b1;
                w_disp[i]  = w_avail;
            end
        end
    end

    // Round-robin among reporting cores: first pass searches from the pointer
    // upward, second pass wraps around to the low indices.
    always_comb begin
        w_found     = 1'b0;
        w_sel       = '0;
        w_gidx      = '0;
        w_g_region  = '0;
        w_g_counter = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_report[i] && (i >= int'(r_rr_ptr))) begin
                w_found     = 1'b1;
                w_sel[i]    = 1'b1;
                w_gidx      = c_PTR_W'(i);
                w_g_region  = w_core_reg[i];
                w_g_counter = w_core_cnt[i];
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_report[i]) begin
                w_found     = 1'b1;
                w_sel[i]    = 1'b1;
                w_gidx      = c_PTR_W'(i);
                w_g_region  = w_core_reg[i];
                w_g_counter = w_core_cnt[i];
            end
        end
    end

    // Only one result in flight: a new grant waits until the port is empty.
    assign w_do_grant = w_found & ~r_res_valid;
    assign w_grant    = w_do_grant ? w_sel : '0;
    assign w_ptr_nxt  = (w_gidx == c_PTR_W'(NUM_CORES - 1)) ? '0 : (w_gidx + c_PTR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_all_done <= 1'b0;
            r_next_reg <= '0;
            r_last_reg <= '0;
        end else begin
            if (w_accept) begin
                r_last_reg <= w_lim;
                r_busy     <= ~w_empty_job;
                r_all_done <= w_empty_job;
            end else if (w_finished) begin
                r_busy     <= 1'b0;
                r_all_done <= 1'b1;
            end
            if (w_dispatch) begin
                r_next_reg <= w_cur + (REGION_W + 1)'(1);
            end else if (w_accept) begin
                r_next_reg <= w_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_region  <= '0;
            r_res_counter <= '0;
            r_rr_ptr      <= '0;
        end else if (w_do_grant) begin
            r_res_valid   <= 1'b1;
            r_res_region  <= w_g_region;
            r_res_counter <= w_g_counter;
            r_rr_ptr      <= w_ptr_nxt;
        end else if (r_res_valid && res_ready) begin
            r_res_valid   <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        logic [2:0]          r_state;
        logic                r_valid;
        logic [1:0]          r_cmd;
        logic [REGION_W-1:0] r_region;
        logic [CNT_W-1:0]    r_counter;

        // Every accepted command drops valid on the following edge; START
        // re-raises valid one cycle later so the wrapper sees a clean gap.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= c_ST_IDLE;
                r_valid   <= 1'b0;
                r_cmd     <= c_CMD_READ;
                r_region  <= '0;
                r_counter <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_disp[g]) begin
                            r_state  <= c_ST_LOAD;
                            r_valid  <= 1'b1;
                            r_cmd    <= c_CMD_READ;
                            r_region <= w_cur[REGION_W-1:0];
                        end
                    end
                    c_ST_LOAD: begin
                        if (core_cmd_read[g]) begin
                            r_valid <= 1'b0;
                            r_state <= c_ST_START;
                        end
                    end
                    c_ST_START: begin
                        if (!r_valid) begin
                            r_valid <= 1'b1;
                            r_cmd   <= c_CMD_START;
                        end else if (core_cmd_read[g]) begin
                            r_valid <= 1'b0;
                            r_state <= c_ST_RUN;
                        end
                    end
                    c_ST_RUN: begin
                        if (core_done[g]) begin
                            r_counter <= core_counter[g*CNT_W +: CNT_W];
                            r_state   <= c_ST_REPORT;
                        end
                    end
                    c_ST_REPORT: begin
                        if (w_grant[g]) begin
                            r_state <= c_ST_RESTART;
                            r_valid <= 1'b1;
                            r_cmd   <= c_CMD_RESTART;
                        end
                    end
                    c_ST_RESTART: begin
                        if (core_cmd_read[g]) begin
                            r_valid <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end

        assign w_idle[g]                = (r_state == c_ST_IDLE);
        assign w_report[g]              = (r_state == c_ST_REPORT);
        assign w_core_reg[g]            = r_region;
        assign w_core_cnt[g]            = r_counter;
        assign core_cmd[g*32 +: 32]     = {30'd0, r_cmd};
        assign core_cmd_valid[g]        = r_valid;
        assign core_region[g*32 +: 32]  = 32'(r_region);
    end

    assign busy        = r_busy;
    assign all_done    = r_all_done;
    assign res_valid   = r_res_valid;
    assign res_region  = r_res_region;
    assign res_counter = r_res_counter;

endmodule
`default_nettype wire

// File: tb/tb_des_region_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_des_region_scheduler                                    |
// | Description : Self-checking bench for des_region_scheduler. Behavioural  |
// |               wrapper models answer commands with random delays; every   |
// |               job pushes its expected (region, counter) set into a       |
// |               scoreboard that a separate monitor drains on handshakes.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_des_region_scheduler;

    localparam int NUM_CORES = 4;
    localparam int REGION_W  = 16;
    localparam int CNT_W     = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_start;
    logic [15:0]  region_first;
    logic [15:0]  region_last;
    logic         busy;
    logic         all_done;
    logic [127:0] core_cmd;
    logic [3:0]   core_cmd_valid;
    logic [127:0] core_region;
    logic [3:0]   core_cmd_read;
    logic [3:0]   core_done;
    logic [255:0] core_counter;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_region;
    logic [63:0]  res_counter;

    always #5 clk = ~clk;

    des_region_scheduler #(
        .NUM_CORES (NUM_CORES),
        .REGION_W  (REGION_W),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .job_start      (job_start),
        .region_first   (region_first),
        .region_last    (region_last),
        .busy           (busy),
        .all_done       (all_done),
        .core_cmd       (core_cmd),
        .core_cmd_valid (core_cmd_valid),
        .core_region    (core_region),
        .core_cmd_read  (core_cmd_read),
        .core_done      (core_done),
        .core_counter   (core_counter),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_region     (res_region),
        .res_counter    (res_counter)
    );

    typedef struct {
        logic [15:0] region;
        logic [63:0] counter;
    } res_t;

    int          errors = 0;
    int          checks = 0;
    res_t        exp_q[$];
    logic [31:0] salt = 32'h1234_5678;
    int          lat_lo = 20;
    int          lat_hi = 20;
    bit          sync_done = 1'b0;
    bit          ordered = 1'b0;
    int          ready_mode = 1;
    int          clear_req = 0;

    // Wrapper search result for a region: independent of which core ran it.
    function automatic logic [63:0] f_cnt(input logic [15:0] r);
        return ({48'd0, r} * 64'h9E37_79B9_7F4A_7C15) ^ {salt, 32'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a job yields exactly one result per region in the
    // inclusive range, nothing when the range is reversed.
    task automatic push_job(input logic [15:0] first, input logic [15:0] last);
        if (first <= last) begin
            for (int r = int'(first); r <= int'(last); r++) begin
                exp_q.push_back('{region: 16'(r), counter: f_cnt(16'(r))});
            end
        end
    endtask

    task automatic start_job(input logic [15:0] first, input logic [15:0] last);
        @(negedge clk);
        region_first = first;
        region_last  = last;
        job_start    = 1'b1;
        push_job(first, last);
        @(negedge clk);
        job_start = 1'b0;
        if (first <= last) begin
            check("busy_after_start", 64'(busy), 64'd1);
            check("all_done_after_start", 64'(all_done), 64'd0);
            check("first_valid_latency", 64'(core_cmd_valid[0]), 64'd1);
        end else begin
            check("empty_busy", 64'(busy), 64'd0);
            check("empty_all_done", 64'(all_done), 64'd1);
            check("empty_valid", 64'(core_cmd_valid), 64'd0);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (all_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (all_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: all_done=%0b after %0d cycles, required 1", name, all_done, n);
        end
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        check({name, "_results_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // res_ready driver
    initial begin
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural des_block_wrapper models, one per core.
    bit          rd_pend  [4];
    int          rd_delay [4];
    logic [15:0] m_region [4];
    int          run_t    [4];
    bit          hold     [4];

    initial begin : wrapper_model
        int          clear_seen;
        bit          all_hold;
        logic [31:0] cw;
        clear_seen    = 0;
        core_cmd_read = '0;
        core_done     = '0;
        core_counter  = '0;
        for (int i = 0; i < 4; i++) begin
            rd_pend[i] = 1'b0; rd_delay[i] = 0; m_region[i] = '0; run_t[i] = 0; hold[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            core_cmd_read = '0;
            if (clear_seen != clear_req) begin
                clear_seen = clear_req;
                core_done  = '0;
                for (int i = 0; i < 4; i++) begin
                    rd_pend[i] = 1'b0; run_t[i] = 0; hold[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (run_t[i] > 0) begin
                        run_t[i]--;
                        if (run_t[i] == 0) hold[i] = 1'b1;
                    end
                    if (core_cmd_valid[i]) begin
                        if (!rd_pend[i]) begin
                            rd_pend[i]  = 1'b1;
                            rd_delay[i] = int'($urandom_range(0, 2));
                        end
                        if (rd_delay[i] == 0) begin
                            rd_pend[i]       = 1'b0;
                            core_cmd_read[i] = 1'b1;
                            cw = core_cmd[i*32 +: 32];
                            checks++;
                            if (!(cw == 32'd0 || cw == 32'd1 || cw == 32'd3)) begin
                                errors++;
                                $display("FAIL core_cmd: core %0d got 0x%0h required 0, 1 or 3", i, cw);
                            end
                            if (cw == 32'd0) m_region[i] = core_region[i*32 +: 16];
                            else if (cw == 32'd1) run_t[i] = int'($urandom_range(lat_lo, lat_hi));
                            else if (cw == 32'd3) core_done[i] = 1'b0;
                        end else begin
                            rd_delay[i]--;
                        end
                    end
                end
                all_hold = 1'b1;
                for (int i = 0; i < 4; i++) all_hold = all_hold & hold[i];
                for (int i = 0; i < 4; i++) begin
                    if (hold[i] && (!sync_done || all_hold)) begin
                        core_done[i]             = 1'b1;
                        core_counter[i*64 +: 64] = f_cnt(m_region[i]);
                        hold[i]                  = 1'b0;
                    end
                end
            end
        end
    end

    // Result monitor: drains the scoreboard on every handshake and checks
    // that a stalled result stays put.
    initial begin : monitor
        bit          prev_stall;
        logic [15:0] prev_r;
        logic [63:0] prev_c;
        int          idx;
        res_t        e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("res_hold_valid", 64'(res_valid), 64'd1);
                check("res_hold_region", 64'(res_region), 64'(prev_r));
                check("res_hold_counter", res_counter, prev_c);
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                prev_stall = 1'b0;
                if (ordered) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL res_extra: got region 0x%0h with none outstanding", res_region);
                    end else begin
                        e = exp_q.pop_front();
                        if (res_region !== e.region) begin
                            errors++;
                            $display("FAIL res_order: got region 0x%0h required 0x%0h", res_region, e.region);
                        end
                        check("res_counter_ordered", res_counter, e.counter);
                    end
                end else begin
                    idx = -1;
                    foreach (exp_q[k]) if (idx < 0 && exp_q[k].region == res_region) idx = k;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL res_unexpected: got region 0x%0h, required an outstanding job region", res_region);
                    end else begin
                        check("res_counter", res_counter, exp_q[idx].counter);
                        exp_q.delete(idx);
                    end
                end
            end else if (res_valid === 1'b1) begin
                prev_stall = 1'b1;
                prev_r     = res_region;
                prev_c     = res_counter;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int          n;
        logic [3:0]  seen_valid;
        logic [15:0] f;
        int          len;

        rst          = 1'b1;
        job_start    = 1'b0;
        region_first = '0;
        region_last  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_all_done", 64'(all_done), 64'd0);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_cmd_valid", 64'(core_cmd_valid), 64'd0);
        check("reset_core_cmd", 64'(|core_cmd), 64'd0);
        check("reset_core_region", 64'(|core_region), 64'd0);
        check("reset_res_region", 64'(res_region), 64'd0);
        check("reset_res_counter", res_counter, 64'd0);
        rst = 1'b0;
        clear_req++;

        // All cores finish together while the CPU stalls.
        lat_lo = 20; lat_hi = 20; sync_done = 1'b1; ordered = 1'b1; ready_mode = 0;
        start_job(16'h0020, 16'h0023);
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check("stall_res_valid", 64'(res_valid), 64'd1);
        check("stall_res_region", 64'(res_region), 64'h20);
        check("stall_res_counter", res_counter, f_cnt(16'h0020));
        ready_mode = 1;
        wait_done("sync", 1000);
        sync_done = 1'b0; ordered = 1'b0;

        // Basic four-region job.
        salt = $urandom;
        start_job(16'h0010, 16'h0013);
        wait_done("basic", 1000);

        // Reversed range dispatches nothing.
        start_job(16'h0005, 16'h0002);
        seen_valid = '0;
        repeat (5) begin @(negedge clk); seen_valid = seen_valid | core_cmd_valid; end
        check("empty_no_valid", 64'(seen_valid), 64'd0);
        check("empty_all_done_held", 64'(all_done), 64'd1);

        // Top of the region space must not wrap.
        salt = $urandom;
        lat_lo = 3; lat_hi = 12;
        start_job(16'hFFFE, 16'hFFFF);
        wait_done("top", 1000);

        // A job_start while busy is ignored.
        salt = $urandom;
        lat_lo = 5; lat_hi = 15; ready_mode = 2;
        start_job(16'h0040, 16'h0049);
        repeat (15) @(negedge clk);
        region_first = 16'h0000;
        region_last  = 16'h0003;
        job_start    = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("midjob_busy", 64'(busy), 64'd1);
        wait_done("midjob", 2000);

        // Randomized jobs, including reversed ranges.
        for (int j = 0; j < 6; j++) begin
            salt   = $urandom;
            lat_lo = int'($urandom_range(1, 8));
            lat_hi = lat_lo + int'($urandom_range(0, 25));
            f      = 16'($urandom_range(1, 16'hFFF0));
            len    = int'($urandom_range(0, 13)) - 1;
            start_job(f, 16'(int'(f) + len));
            wait_done("random", 3000);
        end

        // Reset while cores are running.
        ready_mode = 1; lat_lo = 200; lat_hi = 200;
        start_job(16'h0100, 16'h0103);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_valid", 64'(core_cmd_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_all_done", 64'(all_done), 64'd0);
        rst = 1'b0;
        clear_req++;
        exp_q.delete();
        lat_lo = 5; lat_hi = 10;
        salt = $urandom;
        start_job(16'h0000, 16'h0001);
        wait_done("after_rst", 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
